video_stream_gen: RTL and testbench
===================================

# video_stream_gen

Synthetic pixel-stream source for the edge-detection path. It generates frames of 8-bit greyscale pixels with data_valid, hs and vs framing, using the same active-high in-window convention that the Sobel stage consumes. It is used to drive that stage and its neighbours on the bench and in on-board self-test, with no camera attached. It has no backpressure port, so consumers must accept every valid pixel; stall only inserts gaps at the source.

## Interface
- DATA_WIDTH, 8, pixel width
- H_ACTIVE, 640, pixels per line (≥3)
- H_BLANK, 160, hs-low cycles between lines (≥1)
- V_ACTIVE, 480, lines per frame (≥3)
- V_BLANK, 45, cycles between last pixel of a frame and first cycle of the next (≥1)
- clk  in  1  pixel clock
- reset_p  in  1  asynchronous, active-high reset
- enable  in  1  level; frames run while high
- stall  in  1  inserts an invalid cycle inside an active line
- pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 checker, 3 vertical bar
- data_out  out  DATA_WIDTH  pixel value
- data_out_valid  out  1  pixel qualifier
- data_out_hs  out  1  high across active line
- data_out_vs  out  1  high across active frame
- frame_start  out  1  one-cycle pulse on first output cycle of line 0
- frame_done  out  1  one-cycle pulse on last pixel of frame

## Operation
- States: IDLE, LINE, HBLANK, VBLANK. Counters: h_cnt (0..H_ACTIVE-1), v_cnt (0..V_ACTIVE-1), blank_cnt. Each counter is $clog2 sized.
- All outputs are registered. Reset value is 0 for every output and counter; state resets to IDLE.
- IDLE: all outputs 0. If enable=1, latch pattern_sel, clear h_cnt and v_cnt, and go to LINE.
- LINE, each cycle, sets hs=1 and vs=1, then:
  - stall=0: valid=1, data_out=pattern(h_cnt,v_cnt), h_cnt++.
  - stall=1: valid=0, data_out=0, h_cnt holds.
- LINE exit: after the non-stalled cycle with h_cnt=H_ACTIVE-1, clear h_cnt.
  - If v_cnt=V_ACTIVE-1: go to VBLANK and pulse frame_done in that same pixel cycle.
  - Otherwise: go to HBLANK.
- HBLANK: hs=0, vs=1, valid=0, data_out=0. Lasts exactly H_BLANK cycles, then v_cnt++ and go to LINE.
- VBLANK: hs=0, vs=0, valid=0. Lasts exactly V_BLANK cycles.
  - Then, if enable=1: re-latch pattern_sel, clear v_cnt, and go to LINE (back-to-back frame).
  - Otherwise: go to IDLE.
- frame_start=1 on the first LINE cycle with v_cnt=0, including when that cycle is stalled.
- Patterns (x=h_cnt, y=v_cnt, truncated to DATA_WIDTH):
  - 0: x
  - 1: y
  - 2: all-ones if x[3]^y[3], else 0
  - 3: all-ones if x ≥ H_ACTIVE/2, else 0
- Boundary rules:
  - enable deasserted mid-frame: the frame always completes, VBLANK included, then goes to IDLE.
  - pattern_sel changes mid-frame are ignored until the next latch point.
  - stall in HBLANK, VBLANK or IDLE is ignored; blank durations never stretch.
  - stall held permanently: hs and vs stay high and valid stays 0. This is legal and the block never times out.
  - Reset asserted at any time: state, counters and outputs clear immediately.

## Timing
- enable sampled high in IDLE at edge n: LINE is entered at edge n+1, and the first output cycle (frame_start, pixel (0,0)) is registered at edge n+2.
- Unstalled line: hs high for exactly H_ACTIVE consecutive cycles, all with valid=1.
- Stalled line: hs high for H_ACTIVE plus the number of stalled cycles.
- A stall at edge k affects the output registered at edge k+1.
- Frame period without stalls, back-to-back: V_ACTIVE·H_ACTIVE + (V_ACTIVE-1)·H_BLANK + V_BLANK cycles.
- vs rises with the first hs of line 0 and falls one cycle after the last pixel.
- There is no cycle with valid=1 and hs=0, and no cycle with hs=1 and vs=0.

## Test plan
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=3, DATA_WIDTH=8.

1. Reset with enable=0 for 10 cycles -> all outputs 0. Raise enable -> frame_start exactly 2 edges later, with data_out=0 and valid=1.
2. pattern 0, no stall, enable held high:
   - Pixels per line are 0,1,2,3.
   - hs is high 4 cycles, then low 2 cycles.
   - frame_done comes on the 12th pixel.
   - The next frame_start comes 19 cycles after the previous one.
3. pattern 0, stall high for 2 cycles after the 2nd pixel of line 1 -> hs high 6 cycles, valid pixels 0,1,2,3 with no duplicates, data_out=0 during the stall, line 2 timing shifted by 2.
4. pattern 3 -> every line is 0,0,255,255. Pattern 1 -> lines are 0,0,0,0 / 1,1,1,1 / 2,2,2,2.
5. Drop enable and switch pattern_sel mid-line 1 -> the frame completes with the original pattern, followed by 3 VBLANK cycles, then IDLE, with no further frame_start.
6. Assert reset_p mid-line 1 for 1 cycle -> outputs 0 immediately. After release with enable=1, a new frame starts at pixel (0,0) 2 edges later.

Source files
------------

// File: rtl/video_stream_gen.sv
// Synthetic greyscale frame source with valid/hs/vs framing for the edge-detection path.
// Enable and stall pass through one input register stage. All outputs are registered
// from the current state, so a first pixel appears two edges after enable is sampled
// and a stall affects the output one edge after it is sampled.
module video_stream_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 160,
  parameter int V_ACTIVE   = 480,
  parameter int V_BLANK    = 45
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  enable,
  input  logic                  stall,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  data_out_hs,
  output logic                  data_out_vs,
  output logic                  frame_start,
  output logic                  frame_done
);

  localparam int HW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int VW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);

  typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [BW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [1:0]      pattern_q, pattern_d;
  logic            first_q, first_d;
  logic            enable_q, stall_q;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  hs_q, hs_d;
  logic                  vs_q, vs_d;
  logic                  fs_q, fs_d;
  logic                  fd_q, fd_d;

  // Bit 3 of each coordinate drives the 8x8 checkerboard; zero when the counter is narrower.
  logic x_b3, y_b3;
  assign x_b3 = |(32'(h_cnt_q) & 32'd8);
  assign y_b3 = |(32'(v_cnt_q) & 32'd8);

  logic [DATA_WIDTH-1:0] pix_val;

  // Pixel value for the current (h_cnt, v_cnt) under the latched pattern.
  always_comb begin
    pix_val = '0;
    case (pattern_q)
      2'd0:    pix_val = DATA_WIDTH'(h_cnt_q);
      2'd1:    pix_val = DATA_WIDTH'(v_cnt_q);
      2'd2:    pix_val = (x_b3 ^ y_b3) ? '1 : '0;
      default: pix_val = (32'(h_cnt_q) >= 32'(H_ACTIVE / 2)) ? '1 : '0;
    endcase
  end

  // Register the enable level and the stall request once before the FSM sees them.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      enable_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      enable_q <= enable;
      stall_q  <= stall;
    end
  end

  // Next state, counters and next output values; idle/blank outputs default to zero.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    blank_cnt_d = blank_cnt_q;
    pattern_d   = pattern_q;
    first_d     = first_q;
    data_d      = '0;
    valid_d     = 1'b0;
    hs_d        = 1'b0;
    vs_d        = 1'b0;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q) begin
          pattern_d   = pattern_sel;
          h_cnt_d     = '0;
          v_cnt_d     = '0;
          blank_cnt_d = '0;
          first_d     = 1'b1;
          state_d     = LINE;
        end
      end
      LINE: begin
        hs_d    = 1'b1;
        vs_d    = 1'b1;
        fs_d    = first_q;
        first_d = 1'b0;
        if (!stall_q) begin
          valid_d = 1'b1;
          data_d  = pix_val;
          if (h_cnt_q == H_LAST) begin
            h_cnt_d     = '0;
            blank_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
              fd_d    = 1'b1;
              state_d = VBLANK;
            end else begin
              state_d = HBLANK;
            end
          end else begin
            h_cnt_d = h_cnt_q + HW'(1);
          end
        end
      end
      HBLANK: begin
        vs_d = 1'b1;
        if (blank_cnt_q == HB_LAST) begin
          blank_cnt_d = '0;
          v_cnt_d     = v_cnt_q + VW'(1);
          state_d     = LINE;
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      VBLANK: begin
        if (blank_cnt_q == VB_LAST) begin
          blank_cnt_d = '0;
          v_cnt_d     = '0;
          if (enable_q) begin
            pattern_d = pattern_sel;
            first_d   = 1'b1;
            state_d   = LINE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and latched pattern.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      blank_cnt_q <= '0;
      pattern_q   <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      pattern_q   <= pattern_d;
      first_q     <= first_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign data_out_hs    = hs_q;
  assign data_out_vs    = vs_q;
  assign frame_start    = fs_q;
  assign frame_done     = fd_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: directed frame sequences, a pattern table, and randomized
// enable/stall/pattern/reset traffic, all checked cycle by cycle against a frame-template model.
module tb_video_stream_gen;

  localparam int DW = 8;
  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 3;

  logic          clk = 1'b0;
  logic          reset_p;
  logic          enable;
  logic          stall;
  logic [1:0]    pattern_sel;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_hs;
  logic          data_out_vs;
  logic          frame_start;
  logic          frame_done;

  always #5 clk = ~clk;

  video_stream_gen #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .enable        (enable),
    .stall         (stall),
    .pattern_sel   (pattern_sel),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_hs   (data_out_hs),
    .data_out_vs   (data_out_vs),
    .frame_start   (frame_start),
    .frame_done    (frame_done)
  );

  logic [12:0] act_vec;
  assign act_vec = {frame_start, frame_done, data_out_vs, data_out_hs, data_out_valid, data_out};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: a frame is a queue of output-cycle templates ----------
  typedef struct {int kind; int x; int y;} item_t;   // kind 0 pixel, 1 hblank, 2 vblank
  item_t       mq[$];
  bit          m_en_prev, m_st_prev, m_first;
  int          m_pat;
  logic [12:0] exp_vec;

  function automatic logic [7:0] pix_value(input int pat, input int x, input int y);
    case (pat)
      0:       return 8'(x);
      1:       return 8'(y);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return (x >= HA / 2) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_en_prev = 0;
    m_st_prev = 0;
    m_first   = 0;
    m_pat     = 0;
  endtask

  task automatic model_fill(input int pat);
    item_t it;
    m_pat = pat;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        it = '{kind: 0, x: x, y: y};
        mq.push_back(it);
      end
      for (int b = 0; b < ((y < VA - 1) ? HB : VB); b++) begin
        it = '{kind: (y < VA - 1) ? 1 : 2, x: 0, y: y};
        mq.push_back(it);
      end
    end
  endtask

  // Expected outputs registered at this edge, from the inputs present at the edge.
  task automatic model_edge();
    item_t it;
    bit    en_now, st_now;
    int    ps_now;
    logic  fs, fd, vs, hs, vl;
    logic [7:0] d;
    en_now = enable;
    st_now = stall;
    ps_now = int'(pattern_sel);
    fs = 0; fd = 0; vs = 0; hs = 0; vl = 0; d = 8'h00;
    if (reset_p) begin
      model_reset();
      exp_vec = '0;
      return;
    end
    if (mq.size() > 0) begin
      it = mq[0];
      if (it.kind == 0) begin
        hs = 1; vs = 1; fs = m_first; m_first = 0;
        if (!m_st_prev) begin
          vl = 1;
          d  = pix_value(m_pat, it.x, it.y);
          fd = (it.x == HA - 1) && (it.y == VA - 1);
          void'(mq.pop_front());
        end
      end else begin
        vs = (it.kind == 1);
        void'(mq.pop_front());
      end
    end
    if (mq.size() == 0 && m_en_prev) begin
      model_fill(ps_now);
      m_first = 1;
    end
    m_en_prev = en_now;
    m_st_prev = st_now;
    exp_vec = {fs, fd, vs, hs, vl, d};
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("cycle_outputs", 32'(act_vec), 32'(exp_vec));
  endtask

  task automatic wait_fs(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (frame_start === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("frame_start_timeout", 32'(frame_start), 32'd1);
  endtask

  // ---------------- capture of one frame starting at a frame_start cycle -------------------
  logic [63:0] cap_hs, cap_vs, cap_valid;
  logic [7:0]  cap_data [64];
  logic [7:0]  cap_pix[$];
  int          cap_fd_idx, cap_fd_pix, cap_fs_idx;

  task automatic record(input int i);
    cap_hs[i]    = data_out_hs;
    cap_vs[i]    = data_out_vs;
    cap_valid[i] = data_out_valid;
    cap_data[i]  = data_out;
    if (data_out_valid === 1'b1) cap_pix.push_back(data_out);
    if (frame_done === 1'b1) begin
      cap_fd_idx = i;
      cap_fd_pix = cap_pix.size();
    end
    if (i > 0 && frame_start === 1'b1 && cap_fs_idx < 0) cap_fs_idx = i;
  endtask

  // st_mask bit j: drive stall high after observing cycle j. drop_at: after observing that
  // cycle, drop enable and switch pattern_sel.
  task automatic capture(input int n, input logic [63:0] st_mask, input int drop_at);
    cap_hs = '0; cap_vs = '0; cap_valid = '0;
    cap_pix.delete();
    cap_fd_idx = -1; cap_fd_pix = -1; cap_fs_idx = -1;
    record(0);
    for (int i = 1; i < n; i++) begin
      stall = st_mask[i-1];
      if (i - 1 == drop_at) begin
        enable      = 1'b0;
        pattern_sel = 2'd1;
      end
      tick();
      record(i);
    end
    stall = 1'b0;
  endtask

  typedef struct {logic [1:0] pat; int line; logic [31:0] exp_line;} vec_t;
  vec_t tbl [12];

  initial begin
    int n_frames;
    logic [31:0] got;

    tbl[0]  = '{pat: 2'd3, line: 0, exp_line: 32'h0000FFFF};
    tbl[1]  = '{pat: 2'd3, line: 1, exp_line: 32'h0000FFFF};
    tbl[2]  = '{pat: 2'd3, line: 2, exp_line: 32'h0000FFFF};
    tbl[3]  = '{pat: 2'd1, line: 0, exp_line: 32'h00000000};
    tbl[4]  = '{pat: 2'd1, line: 1, exp_line: 32'h01010101};
    tbl[5]  = '{pat: 2'd1, line: 2, exp_line: 32'h02020202};
    tbl[6]  = '{pat: 2'd2, line: 0, exp_line: 32'h00000000};
    tbl[7]  = '{pat: 2'd2, line: 1, exp_line: 32'h00000000};
    tbl[8]  = '{pat: 2'd2, line: 2, exp_line: 32'h00000000};
    tbl[9]  = '{pat: 2'd0, line: 0, exp_line: 32'h00010203};
    tbl[10] = '{pat: 2'd0, line: 1, exp_line: 32'h00010203};
    tbl[11] = '{pat: 2'd0, line: 2, exp_line: 32'h00010203};

    reset_p = 1'b1; enable = 1'b0; stall = 1'b0; pattern_sel = 2'd0;
    model_reset();

    // Reset, then idle with enable low.
    repeat (10) tick();
    check("reset_outputs", 32'(act_vec), 32'd0);
    reset_p = 1'b0;
    repeat (3) tick();
    check("idle_outputs", 32'(act_vec), 32'd0);

    // enable sampled at edge n -> first pixel registered at n+2.
    enable = 1'b1;
    tick(); check("fs_at_n", 32'(frame_start), 32'd0);
    tick(); check("fs_at_n1", 32'(frame_start), 32'd0);
    tick(); check("fs_at_n2", 32'(frame_start), 32'd1);
    check("first_pixel", 32'({data_out_valid, data_out}), 32'h100);
    $display("frame start after enable: valid=%0d data=%0d", data_out_valid, data_out);

    // Unstalled back-to-back frame, pattern 0.
    capture(20, 64'd0, -1);
    check("s2_hs_pattern", 32'(cap_hs[18:0]), 32'(19'b000_1111_00_1111_00_1111));
    check("s2_fd_pixel", 32'(cap_fd_pix), 32'd12);
    check("s2_fd_idx", 32'(cap_fd_idx), 32'd15);
    check("s2_fs_period", 32'(cap_fs_idx), 32'd19);
    for (int k = 0; k < 12; k++) check($sformatf("s2_pix%0d", k), 32'(cap_pix[k]), 32'(k % 4));
    $display("unstalled frame: fd at pixel %0d, next frame_start after %0d cycles", cap_fd_pix, cap_fs_idx);

    // Two stalled cycles after the 2nd pixel of line 1.
    capture(22, 64'hC0, -1);
    check("s3_hs_pattern", 32'(cap_hs[17:0]), 32'(18'b1111_00_111111_00_1111));
    check("s3_line1_valid", 32'(cap_valid[11:6]), 32'(6'b110011));
    check("s3_stall_data0", 32'(cap_data[8]), 32'd0);
    check("s3_stall_data1", 32'(cap_data[9]), 32'd0);
    check("s3_line1_p2", 32'(cap_data[10]), 32'd2);
    check("s3_line2_first", 32'({cap_valid[14], cap_data[14]}), 32'h100);
    check("s3_fd_idx", 32'(cap_fd_idx), 32'd17);
    check("s3_fs_period", 32'(cap_fs_idx), 32'd21);
    for (int k = 0; k < 12; k++) check($sformatf("s3_pix%0d", k), 32'(cap_pix[k]), 32'(k % 4));
    $display("stalled frame: fd at cycle %0d, period %0d", cap_fd_idx, cap_fs_idx);

    // Pattern table: one frame per pattern, one record per line.
    for (int r = 0; r < 12; r++) begin
      if (r % 3 == 0) begin
        pattern_sel = tbl[r].pat;
        wait_fs(40);
        capture(20, 64'd0, -1);
      end
      got = {cap_pix[tbl[r].line*4], cap_pix[tbl[r].line*4+1],
             cap_pix[tbl[r].line*4+2], cap_pix[tbl[r].line*4+3]};
      check($sformatf("pattern%0d_line%0d", tbl[r].pat, tbl[r].line), got, tbl[r].exp_line);
      $display("pattern %0d line %0d: %08h", tbl[r].pat, tbl[r].line, got);
    end

    // Drop enable and switch pattern mid-line 1: frame completes with pattern 0, then idle.
    capture(45, 64'd0, 7);
    check("s5_pix_count", 32'(cap_pix.size()), 32'd12);
    for (int k = 0; k < 12; k++) check($sformatf("s5_pix%0d", k), 32'(cap_pix[k]), 32'(k % 4));
    check("s5_fd_idx", 32'(cap_fd_idx), 32'd15);
    check("s5_vs_frame", 32'(cap_vs[15:0]), 32'h0000FFFF);
    check("s5_vs_after", 32'(cap_vs[44:16]), 32'd0);
    check("s5_hs_after", 32'(cap_hs[44:16]), 32'd0);
    check("s5_valid_after", 32'(cap_valid[44:16]), 32'd0);
    check("s5_no_restart", 32'(cap_fs_idx), 32'hFFFFFFFF);
    $display("enable dropped: frame finished at cycle %0d, idle afterwards", cap_fd_idx);

    // Asynchronous reset mid-line 1, then restart.
    enable = 1'b1;
    pattern_sel = 2'd0;
    wait_fs(10);
    repeat (7) tick();
    #3;
    reset_p = 1'b1;
    #1;
    check("s6_async_clear", 32'(act_vec), 32'd0);
    model_reset();
    tick();
    reset_p = 1'b0;
    tick(); check("s6_fs_at_n", 32'(frame_start), 32'd0);
    tick(); check("s6_fs_at_n1", 32'(frame_start), 32'd0);
    tick(); check("s6_fs_at_n2", 32'(frame_start), 32'd1);
    check("s6_first_pixel", 32'({data_out_valid, data_out}), 32'h100);
    $display("restart after reset: valid=%0d data=%0d", data_out_valid, data_out);

    // Stall held for a long stretch: hs/vs stay high, no valid.
    stall = 1'b1;
    repeat (50) tick();
    check("long_stall_hs_vs_valid", 32'({data_out_hs, data_out_vs, data_out_valid}), 32'b110);
    stall = 1'b0;

    // Randomized traffic.
    n_frames = 0;
    for (int c = 0; c < 3000; c++) begin
      if (enable) enable = ($urandom_range(0, 99) >= 1);
      else        enable = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 5) pattern_sel = 2'($urandom_range(0, 3));
      stall   = ($urandom_range(0, 99) < 20);
      reset_p = ($urandom_range(0, 999) < 2);
      tick();
      if (frame_done === 1'b1) begin
        n_frames++;
        $display("random frame %0d done at cycle %0d", n_frames, cyc);
      end
    end
    reset_p = 1'b0;
    stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
